// File: rtl/dti_word_uart_tx.sv
// dti_word_uart_tx: accepts a wide word and sends it as consecutive UART
// frames (start, DATA_WIDTH bits LSB first, optional parity, stop), lowest
// byte first. Each frame waits for the far end's clear-to-send before its
// start bit.
//
// Optional feature: define DTI_TX_PARITY_EN to insert one even-parity bit
// between the data bits and the stop bit(s). When the macro is undefined the
// PARITY state is never entered.
//
// Valid/ready: a word is transferred on every rising clk edge where
// tx_word_valid and tx_word_ready are both high; tx_word_ready is high only
// while idle, and tx_word_valid is ignored at all other times.
module dti_word_uart_tx #(
    parameter int BAUDRATE        = 115200,
    parameter int FREQ_FPGA       = 50000000,
    parameter int DATA_WIDTH      = 8,
    parameter int INST_DATA_WIDTH = 32,
    parameter int STOP_BIT_WIDTH  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INST_DATA_WIDTH-1:0] tx_word_data,
    input  logic                       tx_word_valid,
    output logic                       tx_word_ready,
    input  logic                       cts_n,
    output logic                       tx,
    output logic                       tx_busy,
    output logic                       tx_done
);

    localparam int CLKS_PER_BIT = FREQ_FPGA / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NUM_BYTES    = INST_DATA_WIDTH / DATA_WIDTH;
    localparam int BYTE_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    // Second stop bit exists only when two stop bits are configured.
    localparam logic              STOP_LAST = (STOP_BIT_WIDTH == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [IDX_W-1:0]           bit_idx;
    logic [BYTE_W-1:0]          byte_cnt;
    logic                       stop_cnt;
    logic [INST_DATA_WIDTH-1:0] shift_reg;
`ifdef DTI_TX_PARITY_EN
    logic                       parity;
`endif

    logic bit_end;

    // End of the current bit time.
    assign bit_end = (bit_cnt == BIT_LAST);

    // Handshake and status derive directly from the registered state.
    assign tx_word_ready = (state == IDLE);
    assign tx_busy       = (state != IDLE);

    // Transmit FSM: state, counters, shift register and the serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
`ifdef DTI_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_word_valid) begin
                        state     <= GAP;
                        shift_reg <= tx_word_data;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end

                // Line held high until the far end allows the next frame.
                GAP: begin
                    tx <= 1'b1;
                    if (!cts_n) begin
                        state   <= START;
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shift_reg[0];
                        bit_cnt <= '0;
                        bit_idx <= '0;
`ifdef DTI_TX_PARITY_EN
                        parity  <= ^shift_reg[DATA_WIDTH-1:0];
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                // The shift register moves one place per bit, so after the
                // last bit of a byte the next byte already sits at bit 0.
                DATA: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_LAST) begin
`ifdef DTI_TX_PARITY_EN
                            state    <= PARITY;
                            tx       <= parity;
`else
                            state    <= STOP;
                            tx       <= 1'b1;
`endif
                            stop_cnt <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (stop_cnt != STOP_LAST) begin
                            stop_cnt <= 1'b1;
                        end else if (byte_cnt < BYTE_LAST) begin
                            state    <= GAP;
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            state   <= IDLE;
                            tx_done <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dti_word_uart_tx.sv
// Bench for dti_word_uart_tx at 16 clocks per bit. A line monitor decodes
// frames from tx and checks each byte against a queue of expected bytes
// pushed when a word is offered. Build with DTI_TX_PARITY_EN to also check
// the even-parity bit and the longer frames.
module tb_dti_word_uart_tx;

    localparam int CPB = 16;
`ifdef DTI_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB + 1;   // plus one GAP cycle
    localparam int WORD_CYC  = 4 * FRAME_CYC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tx_word_data;
    logic        tx_word_valid;
    logic        tx_word_ready;
    logic        cts_n;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    logic [7:0] exp_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int frames_rx = 0;
    int done_cnt  = 0;
    int exp_done  = 0;

    // monitor state
    logic       mon_active = 1'b0;
    int         mon_pos;
    int         mon_bit;
    logic [7:0] mon_byte;
    logic       mon_par;
    logic [7:0] got;

    dti_word_uart_tx #(
        .BAUDRATE       (1),
        .FREQ_FPGA      (16),
        .DATA_WIDTH     (8),
        .INST_DATA_WIDTH(32),
        .STOP_BIT_WIDTH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_word_data (tx_word_data),
        .tx_word_valid(tx_word_valid),
        .tx_word_ready(tx_word_ready),
        .cts_n        (cts_n),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // tx_done pulse counter
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    // Line monitor: samples each bit at its centre, checks framing and
    // pops the scoreboard at the stop bit.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                mon_byte   = '0;
                mon_par    = 1'b0;
            end
        end else begin
            mon_pos++;
            if (mon_pos % CPB == CPB / 2) begin
                mon_bit = mon_pos / CPB;
                if (mon_bit == 0) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_bit <= 8) begin
                    mon_byte[mon_bit-1] = tx;
                end else if (mon_bit < FRAME_BITS - 1) begin
                    mon_par = tx;
                end else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    check("frame_queued", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        check("frame_byte", {24'd0, mon_byte}, {24'd0, got});
`ifdef DTI_TX_PARITY_EN
                        check("parity_bit", {31'd0, mon_par}, {31'd0, ^got});
`endif
                    end
                    frames_rx++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Offer a word, wait for acceptance, then scramble the input bus.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        @(posedge clk); #1;
        while (!tx_word_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", {31'd0, tx_word_ready}, 32'd1);
        tx_word_data  = w;
        tx_word_valid = 1'b1;
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        @(posedge clk); #1;
        acc_cyc       = cyc;
        tx_word_valid = 1'b0;
        tx_word_data  = ~w;
        exp_done++;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (tx_done === 1'b1) break;
            n++;
        end
        check("done_seen", {31'd0, tx_done}, 32'd1);
        lat = cyc - acc_cyc;
        @(negedge clk);
        check("done_width", {31'd0, tx_done}, 32'd0);
        check("ready_after", {31'd0, tx_word_ready}, 32'd1);
        check("busy_after", {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_rx < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("frames_wait", {31'd0, frames_rx >= target}, 32'd1);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int f0;
        int d0;
        int bad_tx;
        int bad_busy;
        logic [31:0] w;

        reset = 1'b1; cts_n = 1'b0; tx_word_valid = 1'b0; tx_word_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_word_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // basic word, timing and pulse
        send_word(32'h1234_5678);
        wait_done(lat);
        check("word_latency", lat, WORD_CYC);

        // random words
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            send_word(w);
            wait_done(lat);
            check("rand_latency", lat, WORD_CYC);
        end

        // clear-to-send withheld at acceptance
        cts_n = 1'b1;
        send_word(32'h1234_5678);
        bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (tx_busy !== 1'b1) bad_busy++;
        end
        check("cts_hold_tx", bad_tx, 0);
        check("cts_hold_busy", bad_busy, 0);
        @(posedge clk); #1;
        cts_n = 1'b0;
        @(negedge clk);
        check("cts_gap_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("cts_start_tx", {31'd0, tx}, 32'd0);
        wait_done(lat);

        // clear-to-send dropped during byte 1
        f0 = frames_rx;
        send_word(32'h1234_5678);
        wait_frames(f0 + 1);
        idle_cycles(60);
        cts_n = 1'b1;
        wait_frames(f0 + 2);
        idle_cycles(200);
        @(negedge clk);
        check("cts_mid_frames", frames_rx, f0 + 2);
        check("cts_mid_tx", {31'd0, tx}, 32'd1);
        check("cts_mid_busy", {31'd0, tx_busy}, 32'd1);
        @(posedge clk); #1;
        cts_n = 1'b0;
        wait_done(lat);

        // offer while busy is ignored
        send_word(32'h1234_5678);
        repeat (300) begin
            @(posedge clk); #1;
            tx_word_valid = 1'b1;
            tx_word_data  = 32'hAAAA_AAAA;
        end
        tx_word_valid = 1'b0;
        wait_done(lat);
        idle_cycles(20);
        check("ignore_queue_empty", exp_q.size(), 0);

        // reset during byte 2
        f0 = frames_rx;
        send_word(32'h1234_5678);
        wait_frames(f0 + 2);
        idle_cycles(50);
        d0 = done_cnt;
        reset = 1'b1;
        exp_q.delete();
        exp_done--;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_ready", {31'd0, tx_word_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_done", {31'd0, tx_done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(40);
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_frames", frames_rx, f0 + 2);
        send_word(32'h0000_00FF);
        wait_done(lat);
        check("post_rst_latency", lat, WORD_CYC);

        idle_cycles(200);
        check("final_queue_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dti_word_uart_tx.md
DTI_WORD_UART_TX -- requirements
Module: dti_word_uart_tx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 115200, serial line bit rate in bit/s.
REQ-002 SHALL have parameter FREQ_FPGA, default 50000000, clk frequency in Hz.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per UART frame.
REQ-004 SHALL have parameter INST_DATA_WIDTH, default 32, width of the accepted word, an integer multiple of DATA_WIDTH.
REQ-005 SHALL have parameter STOP_BIT_WIDTH, default 1, stop bits per frame (1 or 2).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port tx_word_data  input  INST_DATA_WIDTH  word to transmit.
REQ-009 SHALL have port tx_word_valid  input  1  tx_word_data is valid.
REQ-010 SHALL have port tx_word_ready  output  1  block can accept a word this cycle.
REQ-011 SHALL have port cts_n  input  1  active-low clear-to-send from the far end.
REQ-012 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-013 SHALL have port tx_busy  output  1  a word is in progress.
REQ-014 SHALL have port tx_done  output  1  single-cycle pulse at word completion.

Function
REQ-015 SHALL define CLKS_PER_BIT = FREQ_FPGA / BAUDRATE (integer division); every line bit SHALL last exactly CLKS_PER_BIT clk cycles.
REQ-016 SHALL drive tx_word_ready = 1 only in state IDLE; a word is accepted on any cycle with tx_word_valid & tx_word_ready.
REQ-017 SHALL register tx_word_data into an internal shift register at acceptance; later changes on tx_word_data SHALL NOT affect the transfer.
REQ-018 SHALL ignore tx_word_valid whenever tx_word_ready = 0 (no queuing, no error).
REQ-019 SHALL implement states IDLE, GAP, START, DATA, PARITY, STOP.
REQ-020 SHALL transition IDLE -> GAP on acceptance, resetting the byte counter to 0.
REQ-021 SHALL remain in GAP while cts_n = 1 with tx = 1, and move GAP -> START on the first cycle cts_n = 0.
REQ-022 SHALL drive tx = 0 for one bit time in START, then DATA.
REQ-023 SHALL, in DATA, send DATA_WIDTH bits LSB first from the lowest unsent byte of the word (byte 0 = bits [DATA_WIDTH-1:0] first).
REQ-024 SHALL go DATA -> PARITY when parity is compiled in, else DATA -> STOP.
REQ-025 SHALL drive tx = 1 for STOP_BIT_WIDTH bit times in STOP.
REQ-026 SHALL, at end of STOP, go to GAP if bytes remain (counter < INST_DATA_WIDTH/DATA_WIDTH - 1, then increment), else go to IDLE.
REQ-027 SHALL pulse tx_done high for exactly one cycle, on the cycle the FSM enters IDLE from STOP.
REQ-028 SHALL assert tx_busy in every state except IDLE.
REQ-029 SHALL restart the bit-time counter from 0 on every state entry; cts_n changes during a frame SHALL NOT abort it.
REQ-030 SHALL return to IDLE on any illegal state encoding.

Reset
REQ-031 SHALL, while reset = 1 at a clk edge, set state IDLE, tx = 1, tx_word_ready = 1, tx_busy = 0, tx_done = 0, and clear the counters and shift register.
REQ-032 SHALL abort any transfer when reset is asserted mid-frame; the partial word SHALL be discarded, with no tx_done.

Configuration
REQ-033 SHALL, when macro DTI_TX_PARITY_EN is defined, transmit one even-parity bit in PARITY (XOR of the byte's data bits) between DATA and STOP.
REQ-034 SHALL, when DTI_TX_PARITY_EN is undefined, omit PARITY entirely (10-bit frame for 8N1).

Verification (FREQ_FPGA=16, BAUDRATE=1, CLKS_PER_BIT=16, cts_n=0 unless stated)
REQ-035 SHALL check: accept 0x12345678 -> tx frames bytes 0x78,0x56,0x34,0x12 LSB first, each 160 cycles (no parity) plus one GAP cycle per byte, tx_done pulses once, tx_word_ready back to 1.
REQ-036 SHALL check: same word with DTI_TX_PARITY_EN -> parity bits 0,0,1,0, frames 176 cycles each.
REQ-037 SHALL check: cts_n=1 at acceptance for 100 cycles -> tx stays 1, tx_busy=1, START begins the cycle after cts_n falls.
REQ-038 SHALL check: cts_n raised during byte 1 DATA -> byte 1 completes, block holds in GAP before byte 2 until cts_n=0.
REQ-039 SHALL check: tx_word_valid=1 with 0xAAAAAAAA while busy on 0x12345678 -> ignored, only 0x12345678 transmitted.
REQ-040 SHALL check: reset pulsed in byte 2 DATA -> next cycle tx=1, tx_word_ready=1, tx_busy=0, no tx_done; new word 0x000000FF then sends correctly.
